wb_seq_ctrl: RTL
================

WB_SEQ_CTRL -- requirements
Module: wb_seq_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clock `clk`, reset `reset`, no other clock or reset.
REQ-002 Ports, in this order (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous active-high reset.
- `m_valid`  in  1  MEM-stage instruction present.
- `m_memread`  in  1  instruction is a load.
- `m_memwrite`  in  1  instruction is a store.
- `m_regwrite`  in  1  instruction writes the register file.
- `m_rd`  in  5  destination register.
- `m_alu`  in  32  ALU result, also the memory address.
- `m_wdata`  in  32  store data.
- `mem_req`  out  1  data-memory request.
- `mem_we`  out  1  request is a write.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_ack`  in  1  memory done; `mem_rdata` is valid.
- `mem_rdata`  in  32  memory read data.
- `stall`  out  1  freeze upstream pipeline.
- `wb_en`  out  1  register-file write strobe.
- `wb_rd`  out  5  write register.
- `wb_sel`  out  1  writeback select: 0 = `wb_alu`, 1 = `wb_rdata`.
- `wb_alu`  out  32  registered ALU result.
- `wb_rdata`  out  32  registered read data.
- `err`  out  1  sticky timeout flag.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS and the single-cycle DONE.
REQ-004 An instruction SHALL be accepted only when `m_valid`=1 and `stall`=0.
REQ-005 Accepting a non-memory instruction in IDLE SHALL have these effects:
- Next cycle: `wb_en` = `m_regwrite` && (`m_rd` != 0), `wb_sel`=0, `wb_alu`=`m_alu`, `wb_rd`=`m_rd`.
- State stays IDLE.
- Back-to-back non-memory instructions SHALL each produce one writeback per cycle.
REQ-006 Accepting a memory instruction SHALL register `m_alu` into `mem_addr` and `m_wdata` into `mem_wdata`, and move to ACCESS. From the next cycle `mem_req`=1 and `mem_we`=`m_memwrite`.
REQ-007 If `m_memread` and `m_memwrite` are both 1, SHALL treat the instruction as a store: `mem_we`=1, no writeback.
REQ-008 `stall` SHALL be 1 exactly when state is ACCESS or DONE. It SHALL be combinational from state only.
REQ-009 In ACCESS, `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` SHALL stay constant until the cycle `mem_ack`=1.
REQ-010 On `mem_ack`=1 in ACCESS, SHALL capture `mem_rdata` into `wb_rdata` and go to DONE. `mem_req` SHALL be 0 from the next cycle.
REQ-011 In DONE (one cycle), for a load with `m_regwrite` and rd != 0, SHALL assert `wb_en`=1 with `wb_sel`=1. Stores SHALL produce `wb_en`=0. Next state IDLE.
REQ-012 Load latency: accept at cycle N, ack at cycle N+k (k≥1) -> `wb_en` at N+k+1, `stall` 1 for cycles N+1..N+k+1.
REQ-013 `wb_en` SHALL be a single-cycle pulse per instruction.
REQ-014 `mem_ack` SHALL be ignored outside ACCESS, and `mem_rdata` ignored unless `mem_ack`=1.
REQ-015 `wb_alu`, `wb_rdata`, `wb_rd` and `wb_sel` SHALL hold their values when `wb_en`=0.

Reset
REQ-016 When `reset`=1 at a clock edge, SHALL go to IDLE with every output 0: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `wb_en`, `wb_rd`, `wb_sel`, `wb_alu`, `wb_rdata`, `err`.
REQ-017 Reset during ACCESS SHALL abandon the access: `mem_req`=0 next cycle and no writeback. Reset SHALL win over a simultaneous `mem_ack` or accept.

Configuration
REQ-018 With macro `WB_SEQ_TIMEOUT_EN` defined, a 4-bit counter SHALL behave as follows:
- Clears on entry to ACCESS and increments each ACCESS cycle without ack.
- If 15 cycles pass in ACCESS without ack, SHALL drop `mem_req`, set `err`=1 (sticky until reset), and go to DONE with `wb_en`=0.
- An ack arriving in the 15th cycle SHALL take priority over the timeout.
REQ-019 Without `WB_SEQ_TIMEOUT_EN`, ACCESS SHALL wait indefinitely, `err` SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-020 ALU burst: 3 consecutive accepts, rd=1/2/3, alu=0x11/0x22/0x33 -> `wb_en` on 3 consecutive cycles with matching rd/`wb_alu`, `wb_sel`=0, `stall` never 1.
REQ-021 Load: addr 0x100, rd=5, ack after 3 cycles with rdata 0xDEADBEEF:
- `mem_req` held 3 cycles with addr 0x100.
- `wb_en` one cycle later with `wb_sel`=1, `wb_rdata`=0xDEADBEEF, `wb_rd`=5.
- `stall` high 4 cycles.
REQ-022 Store plus rd=0: store 0xCAFE to 0x20 with ack at 1 cycle -> `mem_we`=1, `mem_wdata`=0xCAFE, no `wb_en`. ALU instruction with rd=0 -> `wb_en`=0.
REQ-023 Reset mid-ACCESS: assert `reset` at cycle 2 of a load, with ack at the same cycle -> next cycle all outputs 0, state IDLE, no `wb_en`.
REQ-024 `WB_SEQ_TIMEOUT_EN`: load with no ack -> `mem_req` drops after 15 cycles, `err`=1, `wb_en`=0, `stall` releases. Ack at cycle 15 -> normal writeback, `err`=0.

Source files
------------

// File: rtl/wb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wb_seq_ctrl
// Sequences the MEM and WB stages of a simple in-order pipeline.
// Non-memory instructions write back on the cycle after they are accepted.
// Memory instructions freeze the pipeline: IDLE -> ACCESS (wait for mem_ack)
// -> DONE (one writeback cycle) -> IDLE.
//
// Optional feature, enabled by defining WB_SEQ_TIMEOUT_EN:
//   A 4-bit watchdog abandons an access after 15 ACCESS cycles without
//   mem_ack. It sets the sticky err flag and suppresses the writeback.
//   Without the macro, ACCESS waits indefinitely and err is tied to 0.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   m_valid/m_memread/m_memwrite/m_regwrite/m_rd/m_alu/m_wdata
//                            MEM-stage instruction
//   mem_req/mem_we/mem_addr/mem_wdata
//                            data-memory request (held stable in ACCESS)
//   mem_ack/mem_rdata        memory completion and read data
//   stall                    freeze upstream (state is ACCESS or DONE)
//   wb_en/wb_rd/wb_sel/wb_alu/wb_rdata
//                            register-file writeback
//   err                      sticky access-timeout flag
// -----------------------------------------------------------------------------
module wb_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_memread,
    input  logic        m_memwrite,
    input  logic        m_regwrite,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic        wb_sel,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        wb_en_q, wb_en_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_sel_q, wb_sel_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    // Remembered across the access: does this load write back, and where.
    logic        pend_wb_q, pend_wb_d;
    logic [4:0]  pend_rd_q, pend_rd_d;
`ifdef WB_SEQ_TIMEOUT_EN
    logic [3:0]  tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
`endif

    logic is_mem;
    logic rd_ok;

    assign is_mem = m_memread | m_memwrite;
    assign rd_ok  = m_regwrite && (m_rd != 5'd0);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_en_d     = 1'b0;          // writeback is always a single-cycle pulse
        wb_rd_d     = wb_rd_q;
        wb_sel_d    = wb_sel_q;
        wb_alu_d    = wb_alu_q;
        wb_rdata_d  = wb_rdata_q;
        pend_wb_d   = pend_wb_q;
        pend_rd_d   = pend_rd_q;
`ifdef WB_SEQ_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                // stall is 0 in IDLE, so m_valid alone means accept.
                if (m_valid) begin
                    if (is_mem) begin
                        state_d     = ACCESS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = m_memwrite;   // read+write counts as a store
                        mem_addr_d  = m_alu;
                        mem_wdata_d = m_wdata;
                        pend_wb_d   = m_memread && !m_memwrite && rd_ok;
                        pend_rd_d   = m_rd;
`ifdef WB_SEQ_TIMEOUT_EN
                        tmo_cnt_d   = 4'd0;
`endif
                    end else if (rd_ok) begin
                        // Writeback registers only move when a write happens,
                        // so they hold whenever wb_en is low.
                        wb_en_d  = 1'b1;
                        wb_sel_d = 1'b0;
                        wb_alu_d = m_alu;
                        wb_rd_d  = m_rd;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (pend_wb_q) begin
                        wb_en_d    = 1'b1;
                        wb_sel_d   = 1'b1;
                        wb_rd_d    = pend_rd_q;
                        wb_rdata_d = mem_rdata;
                    end
                end
`ifdef WB_SEQ_TIMEOUT_EN
                // Count is 14 during the 15th ACCESS cycle; an ack in that
                // same cycle is handled by the branch above first.
                else if (tmo_cnt_q == 4'd14) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_sel_q    <= 1'b0;
            wb_alu_q    <= 32'd0;
            wb_rdata_q  <= 32'd0;
            pend_wb_q   <= 1'b0;
            pend_rd_q   <= 5'd0;
`ifdef WB_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= 4'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_sel_q    <= wb_sel_d;
            wb_alu_q    <= wb_alu_d;
            wb_rdata_q  <= wb_rdata_d;
            pend_wb_q   <= pend_wb_d;
            pend_rd_q   <= pend_rd_d;
`ifdef WB_SEQ_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign stall     = (state_q == ACCESS) || (state_q == DONE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_sel    = wb_sel_q;
    assign wb_alu    = wb_alu_q;
    assign wb_rdata  = wb_rdata_q;
`ifdef WB_SEQ_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule
